// File: rtl/svci_arb_pkg.sv
// rtl/svci_arb_pkg.sv - shared field layout, opcodes and helpers for the SVCI port arbiter
package svci_arb_pkg;

    localparam int ID_W   = 4;
    localparam int PRTY_W = 1;

    localparam logic [2:0] OPC_RD        = 3'b000;
    localparam logic [2:0] OPC_WR_POSTED = 3'b010;
    localparam logic [2:0] OPC_WR_NP     = 3'b011;

    // Response class carried in rsp opc[3:2]
    localparam logic [1:0] RSP_CLS_RD     = 2'b00;
    localparam logic [1:0] RSP_CLS_WR     = 2'b01;
    localparam logic [1:0] RSP_CLS_PW_ERR = 2'b10;
    localparam logic [1:0] RSP_CLS_ERR    = 2'b11;

    localparam int CMD_PRTY_LSB  = 0;
    localparam int CMD_OPC_LSB   = CMD_PRTY_LSB + PRTY_W;
    localparam int CMD_LEN_LSB   = CMD_OPC_LSB + 3;
    localparam int CMD_WBE_LSB   = CMD_LEN_LSB + 3;
    localparam int CMD_WDATA_LSB = CMD_WBE_LSB + 8;
    localparam int CMD_ADDR_LSB  = CMD_WDATA_LSB + 64;
    localparam int CMD_MID_LSB   = CMD_ADDR_LSB + 64;
    localparam int CMD_W         = CMD_MID_LSB + ID_W;

    localparam int RSP_PRTY_LSB  = 0;
    localparam int RSP_OPC_LSB   = RSP_PRTY_LSB + PRTY_W;
    localparam int RSP_RDATA_LSB = RSP_OPC_LSB + 4;
    localparam int RSP_MID_LSB   = RSP_RDATA_LSB + 64;
    localparam int RSP_W         = RSP_MID_LSB + ID_W;

    typedef struct packed {
        logic [ID_W-1:0]   mid;
        logic [63:0]       addr;
        logic [63:0]       wdata;
        logic [7:0]        wbe;
        logic [2:0]        length;
        logic [2:0]        opc;
        logic [PRTY_W-1:0] prty;
    } cmd_t;

    typedef struct packed {
        logic [ID_W-1:0]   mid;
        logic [63:0]       rdata;
        logic [3:0]        opc;
        logic [PRTY_W-1:0] prty;
    } rsp_t;

    function automatic logic is_posted(input logic [2:0] opc);
        return opc == OPC_WR_POSTED;
    endfunction

endpackage

// File: rtl/svci_rr_arb.sv
// rtl/svci_rr_arb.sv - combinational round-robin pick of the first eligible requester at or after ptr
module svci_rr_arb
    import svci_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_gnt_idx,
    output logic            o_any
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    always_comb begin
        w_found   = 1'b0;
        w_cand    = '0;
        o_gnt     = '0;
        o_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = wrap_idx(i_ptr, k);
            if (!w_found && i_elig[w_cand]) begin
                w_found          = 1'b1;
                o_gnt_idx        = w_cand;
                o_gnt[w_cand]    = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/svci_arb.sv
// rtl/svci_arb.sv - shares one SVCI command/response port between NREQ requesters
module svci_arb
    import svci_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TAG     = 3,
    parameter int MAX_OUT = 4,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_cmd_valid,
    output logic [NREQ-1:0]       req_cmd_ready,
    input  logic [NREQ*TAG-1:0]   req_cmd_tag,
    input  logic [NREQ*CMD_W-1:0] req_cmd_pld,
    output logic                  svc_cmd_valid,
    input  logic                  svc_cmd_ready,
    output logic [TAG+IW-1:0]     svc_cmd_tag,
    output logic [CMD_W-1:0]      svc_cmd_pld,
    input  logic                  svc_rsp_valid,
    output logic                  svc_rsp_ready,
    input  logic [TAG+IW-1:0]     svc_rsp_tag,
    input  logic [RSP_W-1:0]      svc_rsp_pld,
    output logic [NREQ-1:0]       req_rsp_valid,
    input  logic [NREQ-1:0]       req_rsp_ready,
    output logic [TAG-1:0]        req_rsp_tag,
    output logic [RSP_W-1:0]      req_rsp_pld,
    output logic                  rsp_err
);

    localparam int               CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic                r_cmd_valid;
    logic [TAG+IW-1:0]   r_cmd_tag;
    cmd_t                r_cmd_pld;
    logic [IW-1:0]       r_ptr;
    logic [CNT_W-1:0]    r_cnt [NREQ];
    logic                r_rsp_err;

    cmd_t                w_cmd [NREQ];
    logic [TAG-1:0]      w_tag [NREQ];
    logic [NREQ-1:0]     w_posted;
    logic [NREQ-1:0]     w_elig;
    logic [NREQ-1:0]     w_gnt;
    logic [IW-1:0]       w_gnt_idx;
    logic                w_any;
    logic                w_load;

    rsp_t                w_rsp;
    logic [IW-1:0]       w_idx;
    logic [NREQ-1:0]     w_hit;
    logic                w_idx_ok;
    logic                w_rsp_hs;
    logic                w_rsp_counted;
    logic                w_drop;
    logic [NREQ-1:0]     w_inc;
    logic [NREQ-1:0]     w_dec;
    logic [NREQ-1:0]     w_zero;
    logic                w_underflow;

    assign w_load = !r_cmd_valid || svc_cmd_ready;

    assign w_rsp         = svc_rsp_pld;
    assign w_idx         = svc_rsp_tag[TAG+IW-1:TAG];
    assign w_idx_ok      = |w_hit;
    assign w_rsp_hs      = svc_rsp_valid && svc_rsp_ready;
    assign w_rsp_counted = (w_rsp.opc[3:2] != RSP_CLS_PW_ERR);
    assign w_drop        = svc_rsp_valid && !w_idx_ok;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign w_cmd[i]    = req_cmd_pld[i*CMD_W +: CMD_W];
        assign w_tag[i]    = req_cmd_tag[i*TAG +: TAG];
        assign w_posted[i] = is_posted(w_cmd[i].opc);
        assign w_elig[i]   = req_cmd_valid[i] && ((r_cnt[i] < MAX_CNT) || w_posted[i]);
        assign w_hit[i]    = (w_idx == IW'(i));
        assign w_zero[i]   = (r_cnt[i] == '0);
        assign w_inc[i]    = req_cmd_valid[i] && req_cmd_ready[i] && !w_posted[i];
        assign w_dec[i]    = w_rsp_hs && w_hit[i] && w_rsp_counted;
    end

    // An increment landing on the same edge cancels the decrement, so no underflow then
    assign w_underflow = |(w_dec & ~w_inc & w_zero);

    svci_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arb (
        .i_elig    (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign req_cmd_ready = (w_load && !rst) ? w_gnt : '0;

    assign svc_cmd_valid = r_cmd_valid;
    assign svc_cmd_tag   = r_cmd_tag;
    assign svc_cmd_pld   = r_cmd_pld;

    // Out-of-range indices are absorbed here so a stray response cannot wedge the bridge
    assign svc_rsp_ready = w_idx_ok ? |(w_hit & req_rsp_ready) : 1'b1;
    assign req_rsp_valid = rst ? '0 : (w_hit & {NREQ{svc_rsp_valid}});
    assign req_rsp_tag   = svc_rsp_tag[TAG-1:0];
    assign req_rsp_pld   = w_rsp;
    assign rsp_err       = r_rsp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_valid <= 1'b0;
            r_cmd_tag   <= '0;
            r_cmd_pld   <= '0;
            r_ptr       <= '0;
            r_rsp_err   <= 1'b0;
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
        end else begin
            if (w_load) begin
                r_cmd_valid <= w_any;
                if (w_any) begin
                    r_cmd_tag <= {w_gnt_idx, w_tag[w_gnt_idx]};
                    r_cmd_pld <= w_cmd[w_gnt_idx];
                    r_ptr     <= (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i] && !w_zero[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
            if (w_drop || w_underflow) r_rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_svci_arb.sv
// tb/tb_svci_arb.sv - directed scoreboard bench for svci_arb with three requesters
module tb_svci_arb;
    import svci_arb_pkg::*;

    localparam int NREQ    = 3;
    localparam int IW      = 2;
    localparam int TAG     = 3;
    localparam int MAX_OUT = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_cmd_valid;
    logic [NREQ-1:0]       req_cmd_ready;
    logic [NREQ*TAG-1:0]   req_cmd_tag;
    logic [NREQ*CMD_W-1:0] req_cmd_pld;
    logic                  svc_cmd_valid;
    logic                  svc_cmd_ready;
    logic [TAG+IW-1:0]     svc_cmd_tag;
    logic [CMD_W-1:0]      svc_cmd_pld;
    logic                  svc_rsp_valid;
    logic                  svc_rsp_ready;
    logic [TAG+IW-1:0]     svc_rsp_tag;
    logic [RSP_W-1:0]      svc_rsp_pld;
    logic [NREQ-1:0]       req_rsp_valid;
    logic [NREQ-1:0]       req_rsp_ready;
    logic [TAG-1:0]        req_rsp_tag;
    logic [RSP_W-1:0]      req_rsp_pld;
    logic                  rsp_err;

    always #5 clk = ~clk;

    svci_arb #(
        .NREQ    (NREQ),
        .TAG     (TAG),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_cmd_valid (req_cmd_valid),
        .req_cmd_ready (req_cmd_ready),
        .req_cmd_tag   (req_cmd_tag),
        .req_cmd_pld   (req_cmd_pld),
        .svc_cmd_valid (svc_cmd_valid),
        .svc_cmd_ready (svc_cmd_ready),
        .svc_cmd_tag   (svc_cmd_tag),
        .svc_cmd_pld   (svc_cmd_pld),
        .svc_rsp_valid (svc_rsp_valid),
        .svc_rsp_ready (svc_rsp_ready),
        .svc_rsp_tag   (svc_rsp_tag),
        .svc_rsp_pld   (svc_rsp_pld),
        .req_rsp_valid (req_rsp_valid),
        .req_rsp_ready (req_rsp_ready),
        .req_rsp_tag   (req_rsp_tag),
        .req_rsp_pld   (req_rsp_pld),
        .rsp_err       (rsp_err)
    );

    typedef struct packed {
        logic [TAG+IW-1:0] tag;
        logic [CMD_W-1:0]  pld;
    } cmd_exp_t;

    typedef struct packed {
        logic [NREQ-1:0]  vld;
        logic [TAG-1:0]   tag;
        logic [RSP_W-1:0] pld;
    } rsp_exp_t;

    cmd_exp_t cmd_q[$];
    rsp_exp_t rsp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [2:0] opc, input logic [7:0] seed);
        cmd_t c;
        c.mid    = seed[ID_W-1:0];
        c.addr   = {32'hA000_0000, 24'h0, seed};
        c.wdata  = {8{seed}};
        c.wbe    = seed;
        c.length = seed[2:0];
        c.opc    = opc;
        c.prty   = PRTY_W'(^seed);
        return c;
    endfunction

    function automatic logic [RSP_W-1:0] mk_rsp(input logic [3:0] opc, input logic [7:0] seed);
        rsp_t r;
        r.mid   = seed[ID_W-1:0];
        r.rdata = {8{seed ^ 8'h5A}};
        r.opc   = opc;
        r.prty  = PRTY_W'(^seed);
        return r;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [TAG-1:0] t, input logic [CMD_W-1:0] p);
        req_cmd_valid[i]             = v;
        req_cmd_tag[i*TAG +: TAG]    = t;
        req_cmd_pld[i*CMD_W +: CMD_W] = p;
    endtask

    task automatic push_cmd(input int i, input logic [TAG-1:0] t, input logic [CMD_W-1:0] p);
        cmd_exp_t e;
        e.tag = {IW'(i), t};
        e.pld = p;
        cmd_q.push_back(e);
    endtask

    task automatic set_rsp(input logic v, input logic [IW-1:0] idx, input logic [TAG-1:0] t, input logic [RSP_W-1:0] p);
        svc_rsp_valid = v;
        svc_rsp_tag   = {idx, t};
        svc_rsp_pld   = p;
    endtask

    task automatic push_rsp(input int i, input logic [TAG-1:0] t, input logic [RSP_W-1:0] p);
        rsp_exp_t e;
        e.vld = NREQ'(1) << i;
        e.tag = t;
        e.pld = p;
        rsp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cmd_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && svc_cmd_valid && svc_cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    n_total++;
                    $display("FAIL cmd_unexpected: got tag %0h with no expected command", svc_cmd_tag);
                end else begin
                    e = cmd_q.pop_front();
                    chk("cmd_tag", svc_cmd_tag, e.tag);
                    chk("cmd_pld", svc_cmd_pld, e.pld);
                end
            end
        end
    end

    initial begin
        rsp_exp_t e;
        forever begin
            @(negedge clk);
            if (|(req_rsp_valid & req_rsp_ready)) begin
                if (rsp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rsp_unexpected: got valid %0b with no expected response", req_rsp_valid);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_valid", req_rsp_valid, e.vld);
                    chk("rsp_tag", req_rsp_tag, e.tag);
                    chk("rsp_pld", req_rsp_pld, e.pld);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary line");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [RSP_W-1:0] rp;

        req_cmd_valid = '0;
        req_cmd_tag   = '0;
        req_cmd_pld   = '0;
        svc_cmd_ready = 1'b1;
        req_rsp_ready = '1;
        set_rsp(1'b1, 2'd1, 3'h0, '0);
        set_req(0, 1'b1, 3'h1, mk_cmd(OPC_RD, 8'h10));
        set_req(1, 1'b1, 3'h2, mk_cmd(OPC_RD, 8'h21));

        // Reset state: requests pending but nothing may be accepted or routed
        @(negedge clk);
        chk("rst_svc_valid", svc_cmd_valid, 0);
        chk("rst_cmd_ready", req_cmd_ready, 0);
        chk("rst_rsp_valid", req_rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        svc_rsp_valid = 1'b0;
        next_cycle();
        rst = 1'b0;

        // Fairness: two continuous readers alternate starting at requester 0
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("fair_gnt", req_cmd_ready, (c % 2 == 0) ? 3'b001 : 3'b010);
            if (c % 2 == 0) push_cmd(0, 3'h1, mk_cmd(OPC_RD, 8'h10));
            else            push_cmd(1, 3'h2, mk_cmd(OPC_RD, 8'h21));
            if (c > 0) chk("fair_svc_valid", svc_cmd_valid, 1);
            next_cycle();
        end
        req_cmd_valid = '0;
        @(negedge clk);
        chk("fair_last_valid", svc_cmd_valid, 1);
        next_cycle();
        @(negedge clk);
        chk("out_clear", svc_cmd_valid, 0);
        next_cycle();

        // Response routing with requester 1 holding off for two cycles
        rp = mk_rsp(4'b0000, 8'h55);
        set_rsp(1'b1, 2'd1, 3'h5, rp);
        req_rsp_ready = 3'b101;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rt_valid", req_rsp_valid, 3'b010);
            chk("rt_hold", svc_rsp_ready, 0);
            next_cycle();
        end
        req_rsp_ready = 3'b111;
        push_rsp(1, 3'h5, rp);
        @(negedge clk);
        chk("rt_ready", svc_rsp_ready, 1);
        next_cycle();
        rp = mk_rsp(4'b0000, 8'h66);
        set_rsp(1'b1, 2'd1, 3'h6, rp);
        push_rsp(1, 3'h6, rp);
        next_cycle();
        for (int j = 0; j < 2; j++) begin
            rp = mk_rsp(4'b0001, 8'h70 + 8'(j));
            set_rsp(1'b1, 2'd0, 3'(j), rp);
            push_rsp(0, 3'(j), rp);
            next_cycle();
        end
        svc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("drain_no_err", rsp_err, 0);
        next_cycle();

        // Throttle: requester 0 gets four reads in, the fifth waits for a response
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b1, 3'(c), mk_cmd(OPC_RD, 8'h30 + 8'(c)));
            @(negedge clk);
            chk("thr_accept", req_cmd_ready, 3'b001);
            push_cmd(0, 3'(c), mk_cmd(OPC_RD, 8'h30 + 8'(c)));
            next_cycle();
        end
        set_req(0, 1'b1, 3'h4, mk_cmd(OPC_RD, 8'h34));
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk("thr_stall", req_cmd_ready, 3'b000);
            next_cycle();
        end
        rp = mk_rsp(4'b0000, 8'h77);
        set_rsp(1'b1, 2'd0, 3'h7, rp);
        push_rsp(0, 3'h7, rp);
        @(negedge clk);
        chk("thr_stall_rsp", req_cmd_ready, 3'b000);
        next_cycle();
        svc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("thr_release", req_cmd_ready, 3'b001);
        push_cmd(0, 3'h4, mk_cmd(OPC_RD, 8'h34));
        next_cycle();
        set_req(0, 1'b0, 3'h0, '0);

        // Backpressure: winner held stable while the bridge stalls
        set_req(1, 1'b1, 3'h3, mk_cmd(OPC_WR_NP, 8'h41));
        @(negedge clk);
        chk("bp_gnt", req_cmd_ready, 3'b010);
        push_cmd(1, 3'h3, mk_cmd(OPC_WR_NP, 8'h41));
        next_cycle();
        svc_cmd_ready = 1'b0;
        set_req(1, 1'b1, 3'h4, mk_cmd(OPC_RD, 8'h42));
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp_valid", svc_cmd_valid, 1);
            chk("bp_tag", svc_cmd_tag, {2'd1, 3'h3});
            chk("bp_pld", svc_cmd_pld, mk_cmd(OPC_WR_NP, 8'h41));
            chk("bp_no_ready", req_cmd_ready, 3'b000);
            next_cycle();
        end
        svc_cmd_ready = 1'b1;
        @(negedge clk);
        chk("bp_load", req_cmd_ready, 3'b010);
        push_cmd(1, 3'h4, mk_cmd(OPC_RD, 8'h42));
        next_cycle();
        set_req(1, 1'b0, 3'h0, '0);
        @(negedge clk);
        chk("bp_next_valid", svc_cmd_valid, 1);
        next_cycle();

        // Posted write bypasses the full counter and its error response is not counted
        set_req(0, 1'b1, 3'h2, mk_cmd(OPC_WR_POSTED, 8'h50));
        @(negedge clk);
        chk("pw_gnt", req_cmd_ready, 3'b001);
        push_cmd(0, 3'h2, mk_cmd(OPC_WR_POSTED, 8'h50));
        next_cycle();
        set_req(0, 1'b0, 3'h0, '0);
        rp = mk_rsp(4'b1000, 8'h58);
        set_rsp(1'b1, 2'd0, 3'h2, rp);
        push_rsp(0, 3'h2, rp);
        next_cycle();
        for (int j = 0; j < 4; j++) begin
            rp = mk_rsp(4'b0000, 8'h60 + 8'(j));
            set_rsp(1'b1, 2'd0, 3'(j), rp);
            push_rsp(0, 3'(j), rp);
            next_cycle();
        end
        svc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("pw_no_err", rsp_err, 0);
        next_cycle();

        // Underflow on requester 0 now that its counter is back at zero
        rp = mk_rsp(4'b0000, 8'h6F);
        set_rsp(1'b1, 2'd0, 3'h5, rp);
        push_rsp(0, 3'h5, rp);
        @(negedge clk);
        chk("uf0_pre", rsp_err, 0);
        next_cycle();
        svc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("uf0_err", rsp_err, 1);
        next_cycle();

        // Reset while a command is stalled at the output
        svc_cmd_ready = 1'b0;
        set_req(2, 1'b1, 3'h6, mk_cmd(OPC_RD, 8'h90));
        @(negedge clk);
        chk("mid_gnt", req_cmd_ready, 3'b100);
        next_cycle();
        set_req(2, 1'b0, 3'h0, '0);
        @(negedge clk);
        chk("mid_stalled", svc_cmd_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", svc_cmd_valid, 0);
        chk("mid_rst_err", rsp_err, 0);
        next_cycle();
        rst = 1'b0;
        svc_cmd_ready = 1'b1;

        // Out-of-range index is dropped and flagged
        set_rsp(1'b1, 2'd3, 3'h1, mk_rsp(4'b0000, 8'hA0));
        @(negedge clk);
        chk("drop_ready", svc_rsp_ready, 1);
        chk("drop_valid", req_rsp_valid, 3'b000);
        next_cycle();
        svc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("drop_err", rsp_err, 1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_err", rsp_err, 0);
        next_cycle();

        // Response to requester 1 with nothing outstanding
        rp = mk_rsp(4'b0100, 8'hB3);
        set_rsp(1'b1, 2'd1, 3'h3, rp);
        push_rsp(1, 3'h3, rp);
        next_cycle();
        svc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("uf1_err", rsp_err, 1);
        next_cycle();
        next_cycle();

        chk("cmd_q_left", cmd_q.size(), 0);
        chk("rsp_q_left", rsp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
